// File: rtl/basemul_ctrl_pkg.sv
// Shared constants, types and the Kyber basemul zeta table for the basemul controller.
// Zeta[i] is the twiddle for pair 2i; pair 2i+1 uses its negation.
package basemul_ctrl_pkg;

    localparam int unsigned KyberQ = 3329;
    localparam int unsigned NPairs = 128;
    localparam int unsigned CoefW  = 16;
    localparam int unsigned AddrW  = 7;

    typedef logic signed [CoefW-1:0] coef_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    typedef struct packed {
        coef_t a1;
        coef_t a0;
        coef_t b1;
        coef_t b0;
        coef_t zeta;
    } bm_ops_t;

    localparam logic [CoefW-1:0] Zeta [64] = '{
        16'd17,   16'd2761, 16'd583,  16'd2649, 16'd1637, 16'd723,  16'd2288, 16'd1100,
        16'd1409, 16'd2662, 16'd3281, 16'd233,  16'd756,  16'd2156, 16'd3015, 16'd3050,
        16'd1703, 16'd1651, 16'd2789, 16'd1789, 16'd1847, 16'd952,  16'd1461, 16'd2687,
        16'd939,  16'd2308, 16'd2437, 16'd2388, 16'd733,  16'd2337, 16'd268,  16'd641,
        16'd1584, 16'd2298, 16'd2037, 16'd3220, 16'd375,  16'd2549, 16'd2090, 16'd1645,
        16'd1063, 16'd319,  16'd2773, 16'd757,  16'd2099, 16'd561,  16'd2466, 16'd2594,
        16'd2804, 16'd1092, 16'd403,  16'd1026, 16'd1143, 16'd2150, 16'd2775, 16'd886,
        16'd1722, 16'd1212, 16'd1874, 16'd1029, 16'd2110, 16'd2935, 16'd885,  16'd2154
    };

endpackage

// File: rtl/zeta_rom.sv
// Combinational lookup of the 64-entry basemul zeta table.
module zeta_rom
    import basemul_ctrl_pkg::*;
(
    input  logic [5:0] idx_i,
    output coef_t      zeta_o
);

    assign zeta_o = coef_t'(Zeta[idx_i]);

endmodule

// File: rtl/basemul_ctrl.sv
// Sequencer for one 128-pair basemul pass: reads operand RAMs, registers basemul operands,
// and writes results back after a valid/address delay line matched to the basemul latency.
module basemul_ctrl
    import basemul_ctrl_pkg::*;
#(
    parameter int unsigned BM_LATENCY = 3
) (
    input  logic             clk_i,
    input  logic             set_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_en_o,
    output logic [AddrW-1:0] rd_addr_o,
    input  coef_t            rd_a1_i,
    input  coef_t            rd_a0_i,
    input  coef_t            rd_b1_i,
    input  coef_t            rd_b0_i,
    output coef_t            bm_a1_o,
    output coef_t            bm_a0_o,
    output coef_t            bm_b1_o,
    output coef_t            bm_b0_o,
    output coef_t            bm_zeta_o,
    input  coef_t            bm_t1_i,
    input  coef_t            bm_t0_i,
    output logic             wr_en_o,
    output logic [AddrW-1:0] wr_addr_o,
    output coef_t            wr_t1_o,
    output coef_t            wr_t0_o
);

    // Stage 0 lines up with RAM data; the last stage lines up with basemul results.
    localparam int unsigned Depth = 2 + BM_LATENCY;

    state_e           state_q, state_d;
    logic [AddrW-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [Depth-1:0] vld_q, vld_d;
    logic [AddrW-1:0] addr_q [Depth];
    logic [AddrW-1:0] addr_d [Depth];
    bm_ops_t          bm_q, bm_d;
    coef_t            zeta_raw;
    logic             last_wr;

    zeta_rom u_zeta_rom (
        .idx_i  (addr_q[0][AddrW-1:1]),
        .zeta_o (zeta_raw)
    );

    assign rd_en_o   = (state_q == StIssue);
    assign rd_addr_o = cnt_q;
    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign wr_en_o   = vld_q[Depth-1];
    assign wr_addr_o = addr_q[Depth-1];
    assign wr_t1_o   = bm_t1_i;
    assign wr_t0_o   = bm_t0_i;
    assign last_wr   = vld_q[Depth-1] && (addr_q[Depth-1] == AddrW'(NPairs - 1));

    assign bm_a1_o   = bm_q.a1;
    assign bm_a0_o   = bm_q.a0;
    assign bm_b1_o   = bm_q.b1;
    assign bm_b0_o   = bm_q.b0;
    assign bm_zeta_o = bm_q.zeta;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // The done cycle still counts as busy for start acceptance.
                if (start_i && !done_q) begin
                    state_d = StIssue;
                    cnt_d   = '0;
                end
            end
            StIssue: begin
                if (cnt_q == AddrW'(NPairs - 1)) begin
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (last_wr) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vld_d     = {vld_q[Depth-2:0], rd_en_o};
        addr_d[0] = cnt_q;
        for (int i = 1; i < Depth; i++) begin
            addr_d[i] = addr_q[i-1];
        end
    end

    always_comb begin
        bm_d = bm_q;
        if (vld_q[0]) begin
            bm_d.a1   = rd_a1_i;
            bm_d.a0   = rd_a0_i;
            bm_d.b1   = rd_b1_i;
            bm_d.b0   = rd_b0_i;
            bm_d.zeta = addr_q[0][0] ? -zeta_raw : zeta_raw;
        end
    end

    always_ff @(posedge clk_i) begin
        if (set_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            bm_q    <= '0;
            for (int i = 0; i < Depth; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            bm_q    <= bm_d;
            for (int i = 0; i < Depth; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_basemul_ctrl.sv
// Scoreboard bench for basemul_ctrl: latency-3 and latency-5 instances share stimulus,
// each with a behavioural operand RAM and a pipelined basemul stub.
module tb_basemul_ctrl;

    typedef struct {
        int          cyc;
        int          addr;
        logic [15:0] t1;
        logic [15:0] t0;
    } wr_exp_t;

    logic clk = 1'b0;
    logic set;
    logic start;
    int   cyc = 0;
    bit   mon_on = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic        busy [2];
    logic        done [2];
    logic        rd_en [2];
    logic        wr_en [2];
    logic [6:0]  rd_addr [2];
    logic [6:0]  wr_addr [2];
    logic [15:0] rd_a1 [2];
    logic [15:0] rd_a0 [2];
    logic [15:0] rd_b1 [2];
    logic [15:0] rd_b0 [2];
    logic [15:0] bm_a1 [2];
    logic [15:0] bm_a0 [2];
    logic [15:0] bm_b1 [2];
    logic [15:0] bm_b0 [2];
    logic [15:0] bm_zeta [2];
    logic [15:0] bm_t1 [2];
    logic [15:0] bm_t0 [2];
    logic [15:0] wr_t1 [2];
    logic [15:0] wr_t0 [2];

    // Reference model state per instance.
    wr_exp_t wq [2][$];
    int      dq [2][$];
    int      ps [2];
    int      pend [2];
    int      rdend [2];
    int      free_at [2];
    int      kill [2];

    logic [15:0] zc [6] = '{16'd17, 16'hFFEF, 16'd2761, 16'hF537, 16'd583, 16'hFDB9};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int g);
        return (g == 0) ? 3 : 5;
    endfunction

    // gamma_k = 17^(2*bitrev7(k)+1) mod q; odd pairs are the negation of the even ones.
    function automatic logic [15:0] zeta_ref(input int k);
        int          i  = k >> 1;
        int          br = 0;
        longint      r  = 1;
        logic [15:0] z;
        for (int b = 0; b < 6; b++) br |= ((i >> b) & 1) << (5 - b);
        for (int e = 0; e < 2 * br + 1; e++) r = (r * 17) % 3329;
        z = 16'(r);
        if ((k & 1) != 0) z = -z;
        return z;
    endfunction

    task automatic chk(input string nm, input int g, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d cycle=%0d got=%0d expected=%0d", nm, g, cyc, act, exp);
        end
    endtask

    task automatic accept(input int g, input int c);
        wr_exp_t e;
        ps[g]      = c;
        pend[g]    = c + 130 + lat(g);
        rdend[g]   = c + 128;
        free_at[g] = c + 132 + lat(g);
        kill[g]    = 32'h7fff_ffff;
        for (int k = 0; k < 128; k++) begin
            e.cyc  = c + k + 3 + lat(g);
            e.addr = k;
            e.t1   = 16'(k);
            e.t0   = 16'(k + 3) + zeta_ref(k);
            wq[g].push_back(e);
        end
        dq[g].push_back(c + 131 + lat(g));
    endtask

    task automatic abort(input int g, input int c);
        while (wq[g].size() > 0 && wq[g][wq[g].size()-1].cyc > c) void'(wq[g].pop_back());
        while (dq[g].size() > 0 && dq[g][dq[g].size()-1] > c) void'(dq[g].pop_back());
        if (ps[g] >= 0 && c <= pend[g]) begin
            pend[g] = c;
            kill[g] = c;
            if (rdend[g] > c) rdend[g] = c;
        end
        if (free_at[g] > c + 1) free_at[g] = c + 1;
    endtask

    // Drive one cycle's inputs, update the model, advance to just after the next edge.
    task automatic step(input bit st, input bit rs);
        int c = cyc;
        start = st;
        set   = rs;
        for (int g = 0; g < 2; g++) begin
            if (rs) abort(g, c);
            else if (st && c >= free_at[g]) accept(g, c);
        end
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 3 : 5;
        logic [15:0] pt1 [LAT];
        logic [15:0] pt0 [LAT];

        basemul_ctrl #(.BM_LATENCY(LAT)) u_dut (
            .clk_i     (clk),
            .set_i     (set),
            .start_i   (start),
            .busy_o    (busy[g]),
            .done_o    (done[g]),
            .rd_en_o   (rd_en[g]),
            .rd_addr_o (rd_addr[g]),
            .rd_a1_i   (rd_a1[g]),
            .rd_a0_i   (rd_a0[g]),
            .rd_b1_i   (rd_b1[g]),
            .rd_b0_i   (rd_b0[g]),
            .bm_a1_o   (bm_a1[g]),
            .bm_a0_o   (bm_a0[g]),
            .bm_b1_o   (bm_b1[g]),
            .bm_b0_o   (bm_b0[g]),
            .bm_zeta_o (bm_zeta[g]),
            .bm_t1_i   (bm_t1[g]),
            .bm_t0_i   (bm_t0[g]),
            .wr_en_o   (wr_en[g]),
            .wr_addr_o (wr_addr[g]),
            .wr_t1_o   (wr_t1[g]),
            .wr_t0_o   (wr_t0[g])
        );

        always @(posedge clk) begin
            if (rd_en[g]) begin
                rd_a1[g] <= 16'(rd_addr[g]);
                rd_a0[g] <= 16'(rd_addr[g]) + 16'd1;
                rd_b1[g] <= 16'(rd_addr[g]) + 16'd2;
                rd_b0[g] <= 16'(rd_addr[g]) + 16'd3;
            end
        end

        always @(posedge clk) begin
            pt1[0] <= bm_a1[g];
            pt0[0] <= bm_b0[g] + bm_zeta[g];
            for (int i = 1; i < LAT; i++) begin
                pt1[i] <= pt1[i-1];
                pt0[i] <= pt0[i-1];
            end
        end
        assign bm_t1[g] = pt1[LAT-1];
        assign bm_t0[g] = pt0[LAT-1];

        always @(negedge clk) begin
            int      c;
            int      k;
            bit      ew;
            bit      ed;
            wr_exp_t e;
            if (mon_on) begin
                c = cyc;
                ew = (ps[g] >= 0) && (c >= ps[g] + 1) && (c <= rdend[g]);
                chk("rd_en", g, int'(rd_en[g]), int'(ew));
                if (ew) chk("rd_addr", g, int'(rd_addr[g]), c - ps[g] - 1);
                chk("busy", g, int'(busy[g]),
                    int'((ps[g] >= 0) && (c >= ps[g] + 1) && (c <= pend[g])));
                k = c - ps[g] - 3;
                if (ps[g] >= 0 && k >= 0 && k < 128 && c <= kill[g]) begin
                    chk("bm_zeta", g, int'(bm_zeta[g]), int'(zeta_ref(k)));
                    chk("bm_a1", g, int'(bm_a1[g]), k);
                    chk("bm_b0", g, int'(bm_b0[g]), k + 3);
                end
                ew = (wq[g].size() > 0) && (wq[g][0].cyc == c);
                chk("wr_en", g, int'(wr_en[g]), int'(ew));
                if (ew) begin
                    e = wq[g].pop_front();
                    if (wr_en[g]) begin
                        chk("wr_addr", g, int'(wr_addr[g]), e.addr);
                        chk("wr_t1", g, int'(wr_t1[g]), int'(e.t1));
                        chk("wr_t0", g, int'(wr_t0[g]), int'(e.t0));
                    end
                end
                ed = (dq[g].size() > 0) && (dq[g][0] == c);
                chk("done", g, int'(done[g]), int'(ed));
                if (ed) void'(dq[g].pop_front());
            end
        end
    end

    initial begin
        int t;
        for (int g = 0; g < 2; g++) begin
            ps[g] = -1; pend[g] = -1; rdend[g] = -1; free_at[g] = 0; kill[g] = 0;
        end
        set   = 1'b1;
        start = 1'b0;
        repeat (3) step(1'b0, 1'b1);
        mon_on = 1'b1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_busy", g, int'(busy[g]), 0);
            chk("rst_done", g, int'(done[g]), 0);
            chk("rst_rd_en", g, int'(rd_en[g]), 0);
            chk("rst_wr_en", g, int'(wr_en[g]), 0);
            chk("rst_rd_addr", g, int'(rd_addr[g]), 0);
            chk("rst_wr_addr", g, int'(wr_addr[g]), 0);
            chk("rst_bm_zeta", g, int'(bm_zeta[g]), 0);
            chk("rst_bm_a0", g, int'(bm_a0[g]), 0);
            chk("rst_bm_b1", g, int'(bm_b1[g]), 0);
        end
        repeat (2) step(1'b0, 1'b0);

        // Single full pass; explicit zeta constants and latency-5 timing.
        t = cyc;
        step(1'b1, 1'b0);
        for (int i = 1; i < 140; i++) begin
            if (i >= 3 && i < 9) begin
                chk("zeta_const", 0, int'(bm_zeta[0]), int'(zc[i-3]));
                chk("zeta_const", 1, int'(bm_zeta[1]), int'(zc[i-3]));
                chk("bm_a0", 0, int'(bm_a0[0]), i - 3 + 1);
                chk("bm_b1", 0, int'(bm_b1[0]), i - 3 + 2);
            end
            if (i == 6) chk("first_wr_l3", 0, int'(wr_en[0]), 1);
            if (i == 8) chk("first_wr_l5", 1, int'(wr_en[1]), 1);
            if (i == 134) chk("done_l3", 0, int'(done[0]), 1);
            if (i == 136) chk("done_l5", 1, int'(done[1]), 1);
            step(1'b0, 1'b0);
        end
        repeat ($urandom_range(0, 5)) step(1'b0, 1'b0);

        // Start re-pulsed while busy and in the done cycle.
        t = cyc;
        step(1'b1, 1'b0);
        for (int i = 1; i < 140; i++) begin
            if (i == 134) chk("busy_134", 0, int'(busy[0]), 0);
            step(i == 40 || i == 134, 1'b0);
        end
        repeat ($urandom_range(0, 5)) step(1'b0, 1'b0);

        // Abort in cycle 60, restart in cycle 70.
        t = cyc;
        step(1'b1, 1'b0);
        for (int i = 1; i < 212; i++) begin
            if (i == 76) begin
                chk("restart_wr_en", 0, int'(wr_en[0]), 1);
                chk("restart_wr_addr", 0, int'(wr_addr[0]), 0);
            end
            step(i == 70, i == 60);
        end

        // Set and start together.
        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("setstart_rd_en", 0, int'(rd_en[0]), 0);
            step(1'b0, 1'b0);
        end

        // Randomized starts and occasional aborts.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 399) == 0);
        end
        repeat (150) step(1'b0, 1'b0);

        for (int g = 0; g < 2; g++) begin
            chk("writes_left", g, wq[g].size(), 0);
            chk("dones_left", g, dq[g].size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
